// File: rtl/fifo_pack_16to128.sv
// Packs a stream of IN_WIDTH-bit words into OUT_WIDTH-bit beats, first word in the low slot.
// Define FIFO_PACK_FLUSH_EN to let in_last close a partial, zero-padded beat.
module fifo_pack_16to128 #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 128,
  localparam int RATIO    = OUT_WIDTH / IN_WIDTH,
  localparam int LANE_W   = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [LANE_W:0]      out_words,
  output logic                 out_last
);

  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(RATIO - 1);
  localparam logic [LANE_W:0]   FULL_WORDS = (LANE_W + 1)'(RATIO);
  localparam logic [LANE_W-1:0] LANE_ONE   = LANE_W'(1);

  logic [LANE_W-1:0]                lane;
  logic [RATIO-2:0][IN_WIDTH-1:0]   acc;
  logic                             accept;
  logic                             close;
  logic                             last_lane;
  logic                             next_last;
  logic [OUT_WIDTH-1:0]             next_beat;
  logic [LANE_W:0]                  next_words;

  // The output register frees up in the same cycle it is drained, so a
  // completing word can be accepted while the previous beat leaves.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_lane = (lane == LAST_LANE);

`ifdef FIFO_PACK_FLUSH_EN
  assign close     = accept && (last_lane || in_last);
  assign next_last = in_last;

  // Slots below the current lane come from the accumulator, above it are zero.
  always_comb begin
    next_beat = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(lane))
        next_beat[k*IN_WIDTH +: IN_WIDTH] = acc[k];
      else if (k == int'(lane))
        next_beat[k*IN_WIDTH +: IN_WIDTH] = in_data;
    end
    if (last_lane)
      next_beat[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = in_data;
    next_words = {1'b0, lane} + {{LANE_W{1'b0}}, 1'b1};
  end
`else
  logic unused_last;

  assign close       = accept && last_lane;
  assign next_last   = 1'b0;
  assign unused_last = in_last;

  always_comb begin
    next_beat  = {in_data, acc};
    next_words = FULL_WORDS;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      if (close) begin
        lane <= '0;
      end else begin
        acc[lane] <= in_data;
        lane      <= lane + LANE_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_words <= '0;
      out_last  <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= next_beat;
      out_words <= next_words;
      out_last  <= next_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
